// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive frame stage.
//   - CRC-32 constants (reflected polynomial, init value, good-frame residue)
//   - Ethernet header and minimum payload lengths
//   - receive FSM state encoding
//   - crc32_byte(): one-byte reflected CRC-32 update
package eth_pkg;

  localparam logic [31:0] CRC32_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
  localparam int          ETH_HDR_LEN     = 14;
  localparam int          ETH_MIN_PAYLOAD = 46;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    DROP
  } rx_state_e;

  // Bits are consumed LSB first, matching wire order.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Running CRC-32 over received bytes.
//   clk, reset   : clock, synchronous active-high reset (loads init value)
//   clr_i        : restart the CRC at the init value
//   en_i         : fold data_i into the CRC this cycle
//   data_i       : byte to fold in
//   crc_o        : current register value
//   crc_upd_o    : register value after folding data_i (combinational)
module eth_crc32
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o,
  output logic [31:0] crc_upd_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_upd_o = crc32_byte(crc_q, data_i);
    crc_d     = crc_q;
    if (clr_i) begin
      crc_d = CRC32_INIT;
    end else if (en_i) begin
      crc_d = crc_upd_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= CRC32_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/eth_rx_frame.sv
// Ethernet receive frame stage. Strips preamble/SFD, filters on destination
// MAC and EtherType, checks FCS and payload length, and forwards payload
// bytes only (FCS removed) with a per-frame good/bad verdict.
//   clk, reset          : clock, synchronous active-high reset
//   in_vld/in_last/in_data : byte stream from the RMII receiver
//   out_vld/out_data    : payload byte strobe and data
//   out_sof             : marks the first payload byte of a frame
//   out_eof/out_ok      : end-of-frame pulse and its verdict
//   cnt_ok/cnt_bad      : saturating good/bad frame counters
module eth_rx_frame
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [15:0] ETHERTYPE    = 16'h88B5,
  parameter int          MAX_PAYLOAD  = 1500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_vld,
  input  logic        in_last,
  input  logic [7:0]  in_data,
  output logic        out_vld,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_ok,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_bad
);

  localparam logic [10:0]      MAX_LEN = 11'(MAX_PAYLOAD);
  localparam logic [10:0]      MIN_LEN = 11'(ETH_MIN_PAYLOAD);
  localparam logic [3:0]       HDR_END = 4'(ETH_HDR_LEN - 1);
  localparam logic [5:0][7:0]  MAC_B   = MAC_ADDR;  // MAC_B[5] is wire byte 0

  rx_state_e       state_q, state_d;
  logic [3:0]      hdr_idx_q, hdr_idx_d;
  logic            ucast_q, ucast_d;
  logic            bcast_q, bcast_d;
  logic            type_q, type_d;
  logic [3:0][7:0] dly_q, dly_d;      // dly_q[3] is the oldest byte
  logic [2:0]      dly_cnt_q, dly_cnt_d;
  logic [10:0]     len_q, len_d;
  logic            last_prev_q;
  logic            out_vld_q, out_vld_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;
  logic            out_ok_q, out_ok_d;
  logic            eof_pend_q, eof_pend_d;
  logic            ok_pend_q, ok_pend_d;
  logic [15:0]     cnt_ok_q, cnt_ok_d;
  logic [15:0]     cnt_bad_q, cnt_bad_d;

  logic            crc_clr, crc_en;
  logic [31:0]     crc_cur, crc_upd, crc_eff;
  logic            last_first;
  logic            ev_eof, ev_ok, ev_silent_bad, sfd;
  logic            type_fin;
  logic [2:0]      mac_sel;

  eth_crc32 u_crc (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (crc_clr),
    .en_i      (crc_en),
    .data_i    (in_data),
    .crc_o     (crc_cur),
    .crc_upd_o (crc_upd)
  );

  assign last_first = in_last & ~last_prev_q;
  assign mac_sel    = 3'd5 - hdr_idx_q[2:0];
  // A byte arriving together with in_last must be included in the verdict.
  assign crc_eff    = crc_en ? crc_upd : crc_cur;

  always_comb begin
    state_d       = state_q;
    hdr_idx_d     = hdr_idx_q;
    ucast_d       = ucast_q;
    bcast_d       = bcast_q;
    type_d        = type_q;
    dly_d         = dly_q;
    dly_cnt_d     = dly_cnt_q;
    len_d         = len_q;
    out_vld_d     = 1'b0;
    out_data_d    = out_data_q;
    out_sof_d     = 1'b0;
    out_eof_d     = 1'b0;
    out_ok_d      = 1'b0;
    eof_pend_d    = 1'b0;
    ok_pend_d     = 1'b0;
    cnt_ok_d      = cnt_ok_q;
    cnt_bad_d     = cnt_bad_q;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;
    ev_eof        = 1'b0;
    ev_ok         = 1'b0;
    ev_silent_bad = 1'b0;
    sfd           = 1'b0;
    type_fin      = 1'b0;

    // Byte first, end of frame second.
    if (in_vld) begin
      case (state_q)
        IDLE, PREAMBLE: begin
          if (in_data == 8'h55) begin
            state_d = PREAMBLE;
          end else if (in_data == 8'hD5) begin
            sfd = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
        HEADER: begin
          crc_en    = 1'b1;
          hdr_idx_d = hdr_idx_q + 4'd1;
          if (hdr_idx_q < 4'd6) begin
            ucast_d = ucast_q & (in_data == MAC_B[mac_sel]);
            bcast_d = bcast_q & (in_data == 8'hFF);
          end
          if (hdr_idx_q == 4'd12) begin
            type_d = type_q & (in_data == ETHERTYPE[15:8]);
          end
          if (hdr_idx_q == HDR_END) begin
            type_fin = type_q & (in_data == ETHERTYPE[7:0]);
            state_d  = (type_fin && (ucast_q || (ACCEPT_BCAST && bcast_q))) ? PAYLOAD : DROP;
          end
        end
        PAYLOAD: begin
          crc_en = 1'b1;
          dly_d  = {dly_q[2:0], in_data};
          if (dly_cnt_q != 3'd4) begin
            dly_cnt_d = dly_cnt_q + 3'd1;
          end else if (len_q == MAX_LEN) begin
            // Oversize: the byte is withheld and the frame closes as bad.
            ev_eof  = 1'b1;
            state_d = DROP;
          end else begin
            out_vld_d  = 1'b1;
            out_data_d = dly_q[3];
            out_sof_d  = (len_q == 11'd0);
            len_d      = len_q + 11'd1;
          end
        end
        default: ;
      endcase
    end

    if (sfd) begin
      state_d   = HEADER;
      hdr_idx_d = 4'd0;
      ucast_d   = 1'b1;
      bcast_d   = 1'b1;
      type_d    = 1'b1;
      dly_cnt_d = 3'd0;
      len_d     = 11'd0;
      crc_clr   = 1'b1;
    end

    if (last_first) begin
      if (state_d == PAYLOAD) begin
        if (len_d != 11'd0) begin
          ev_eof = 1'b1;
          ev_ok  = (crc_eff == CRC32_RESIDUE) && (len_d >= MIN_LEN);
        end else begin
          ev_silent_bad = 1'b1;
        end
      end
      state_d = IDLE;
    end

    // out_eof may not share a cycle with out_vld; defer it by one clk when
    // the final byte and in_last arrive together (inputs come every 2 clk).
    if (eof_pend_q) begin
      out_eof_d = 1'b1;
      out_ok_d  = ok_pend_q;
    end else if (ev_eof) begin
      if (out_vld_d) begin
        eof_pend_d = 1'b1;
        ok_pend_d  = ev_ok;
      end else begin
        out_eof_d = 1'b1;
        out_ok_d  = ev_ok;
      end
    end

    if (out_eof_d && out_ok_d && (cnt_ok_q != 16'hFFFF)) begin
      cnt_ok_d = cnt_ok_q + 16'd1;
    end
    if (((out_eof_d && !out_ok_d) || ev_silent_bad) && (cnt_bad_q != 16'hFFFF)) begin
      cnt_bad_d = cnt_bad_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hdr_idx_q   <= 4'd0;
      ucast_q     <= 1'b0;
      bcast_q     <= 1'b0;
      type_q      <= 1'b0;
      dly_q       <= '0;
      dly_cnt_q   <= 3'd0;
      len_q       <= 11'd0;
      last_prev_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= 8'h00;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_ok_q    <= 1'b0;
      eof_pend_q  <= 1'b0;
      ok_pend_q   <= 1'b0;
      cnt_ok_q    <= 16'd0;
      cnt_bad_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      ucast_q     <= ucast_d;
      bcast_q     <= bcast_d;
      type_q      <= type_d;
      dly_q       <= dly_d;
      dly_cnt_q   <= dly_cnt_d;
      len_q       <= len_d;
      last_prev_q <= in_last;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_ok_q    <= out_ok_d;
      eof_pend_q  <= eof_pend_d;
      ok_pend_q   <= ok_pend_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_bad_q   <= cnt_bad_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_sof  = out_sof_q;
  assign out_eof  = out_eof_q;
  assign out_ok   = out_ok_q;
  assign cnt_ok   = cnt_ok_q;
  assign cnt_bad  = cnt_bad_q;

endmodule
